vga_sync: RTL and testbench
===========================

Name: vga_sync

Overview:
- Timing generator that sits directly upstream of the pixel generator.
- Divides the system clock down to a pixel-rate enable (p_tick).
- Runs horizontal and vertical scan counters and produces hsync, vsync, video_on, pixel_x and pixel_y.
- The pixel generator consumes these outputs and derives its refresh tick from them; the frame timing of the whole design is owned here.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (legal range ≥2)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- p_tick  out  1  pixel enable, high for one clk every CLK_DIV clks
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- frame_tick  out  1  one-clk pulse on the last pixel of each frame

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_* parameters (default 800); V_TOTAL = sum of the four V_* parameters (default 525). Both must be ≤1024. All counter arithmetic is unsigned, 10 bits.
- Reset: clk, rstn are the single clock and asynchronous active-low reset. While rstn=0:
  - div_cnt=0, h_cnt=0, v_cnt=0
  - hsync=1, vsync=1, p_tick=0, frame_tick=0
  - pixel_x=0, pixel_y=0, video_on=1
  - Deassertion takes effect on the next clk edge; no sync resynchronisation is performed inside this block.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt==CLK_DIV-1), decoded combinationally from the register.
  - First p_tick occurs CLK_DIV-1 clks after reset release.
- Horizontal counter: on a clk edge with p_tick=1, h_cnt increments; at H_TOTAL-1 it wraps to 0. h_cnt never changes when p_tick=0.
- Vertical counter: on a clk edge with p_tick=1 and h_cnt==H_TOTAL-1, v_cnt increments; at V_TOTAL-1 it wraps to 0.
- pixel_x = h_cnt and pixel_y = v_cnt directly; the full blanking range is visible downstream. Values such as pixel_y=481 must occur.
- video_on: combinational from h_cnt and v_cnt, so it is aligned with pixel_x/pixel_y.
- hsync, vsync:
  - Registered, loaded from the next-state counter values, so they change in the same clk edge as the counters. This is zero-latency alignment and glitch-free.
  - hsync=0 iff h_cnt is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (default 656..751).
  - vsync=0 iff v_cnt is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (default 490..491).
- frame_tick = p_tick & (h_cnt==H_TOTAL-1) & (v_cnt==V_TOTAL-1). It is exactly one clk wide, once per frame.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clks (default 840000).
- Simultaneous wrap: when h_cnt and v_cnt both wrap on the same p_tick, both go to 0 on that edge. vsync and hsync return to 1 on that same edge.
- Reset mid-frame: all state returns to the reset values immediately, regardless of the divider phase. The next frame starts cleanly from (0,0).

Test Plan:
- Reset release, defaults → p_tick first high at clk 1 after release, then every 2 clks; pixel_x steps 0,1,2… on each p_tick; video_on=1 at (0,0).
- Horizontal sweep → video_on falls when pixel_x goes 639→640; hsync low exactly for pixel_x 656..751 (96 p_ticks); pixel_x wraps 799→0 and pixel_y increments on that same edge.
- Vertical sweep → vsync low only for pixel_y 490..491 (1600 p_ticks total); pixel_y wraps 524→0 together with pixel_x 799→0; frame_tick high for exactly one clk at that point.
- Two-frame run → frame_tick pulses exactly 840000 clks apart; pixel_y=481 with pixel_x=0 occurs exactly once per frame.
- Assert rstn at pixel (300,200) mid-divider → all outputs take their reset values asynchronously; after release, counting resumes from (0,0) with the full first line timing.
- Override CLK_DIV=4, H_DISPLAY=8, H_FRONT=2, H_SYNC=3, H_BACK=3, V_* = 4,1,1,1 → p_tick every 4 clks; hsync low for pixel_x 10..12; vsync low for pixel_y 5; frame period 16*7*4=448 clks.

Source files
------------

// File: rtl/vga_sync.sv
// VGA timing generator: divides clk down to a pixel enable and runs the
// horizontal/vertical scan counters that drive sync, blanking and pixel coordinates.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          h_last, v_last;

  always_comb begin
    p_tick = (div_q == DIV_LAST);
    h_last = (h_q == H_LAST);
    v_last = (v_q == V_LAST);
    div_d  = p_tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    if (p_tick) begin
      h_d = h_last ? '0 : h_q + 10'd1;
      if (h_last) v_d = v_last ? '0 : v_q + 10'd1;
    end
    // Syncs decode the next counter values so the registered outputs line up
    // with the counters on the same edge.
    hsync_d = !((h_d >= HS_START) && (h_d <= HS_END));
    vsync_d = !((v_d >= VS_START) && (v_d <= VS_END));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pixel_x    = h_q;
  assign pixel_y    = v_q;
  assign video_on   = (h_q < H_VIS) && (v_q < V_VIS);
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = p_tick && h_last && v_last;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-timing instance and a small override instance,
// both checked each cycle against an arithmetic model of the scan position.
module tb_vga_sync;

  logic clk;
  logic rstn;

  logic       pt_a, vo_a, hs_a, vs_a, ft_a;
  logic [9:0] x_a, y_a;
  logic       pt_b, vo_b, hs_b, vs_b, ft_b;
  logic [9:0] x_b, y_b;

  vga_sync u_a (
    .clk(clk), .rstn(rstn), .p_tick(pt_a), .pixel_x(x_a), .pixel_y(y_a),
    .video_on(vo_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
  );

  vga_sync #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(4)
  ) u_b (
    .clk(clk), .rstn(rstn), .p_tick(pt_b), .pixel_x(x_b), .pixel_y(y_b),
    .video_on(vo_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clk edges since reset release; the whole expected state follows from it
  int k;
  always @(posedge clk or negedge rstn)
    if (!rstn) k <= 0;
    else       k <= k + 1;

  logic [24:0] va, vb;
  assign va = {pt_a, x_a, y_a, vo_a, hs_a, vs_a, ft_a};
  assign vb = {pt_b, x_b, y_b, vo_b, hs_b, vs_b, ft_b};

  localparam logic [24:0] RST_V = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [24:0] model(int kk, int d, int hd, int hf, int hs,
                                        int hb, int vd, int vf, int vs, int vb_);
    int ht = hd + hf + hs + hb;
    int vt = vd + vf + vs + vb_;
    int n  = kk / d;
    int h  = n % ht;
    int v  = (n / ht) % vt;
    logic pt = ((kk % d) == d - 1);
    return {pt, 10'(h), 10'(v), (h < hd) && (v < vd),
            !(h >= hd + hf && h < hd + hf + hs),
            !(v >= vd + vf && v < vd + vf + vs),
            pt && (h == ht - 1) && (v == vt - 1)};
  endfunction

  function automatic logic [24:0] exp_a(int kk);
    return model(kk, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [24:0] exp_b(int kk);
    return model(kk, 4, 8, 2, 3, 3, 4, 1, 1, 1);
  endfunction

  task automatic reset_release();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (va !== RST_V) $display("FAIL reset_a got=%h exp=%h", va, RST_V);
      else n_pass++;
      n_chk++;
      if (vb !== RST_V) $display("FAIL reset_b got=%h exp=%h", vb, RST_V);
      else n_pass++;
    end
  endtask

  task automatic test_first_ticks();
    reset_release();
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_chk++;
      if ({pt_a, x_a} !== {(i % 2) == 1, 10'(i / 2)})
        $display("FAIL first_ticks i=%0d got pt=%b x=%0d exp pt=%b x=%0d",
                 i, pt_a, x_a, (i % 2) == 1, i / 2);
      else n_pass++;
      if (i <= 2) begin
        n_chk++;
        if (vo_a !== 1'b1) $display("FAIL video_on_origin got=%b exp=1", vo_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_h_sweep();
    int hs_low = 0;
    int wraps  = 0;
    reset_release();
    repeat (3 * 1600 + 20) begin
      @(negedge clk);
      n_chk++;
      if (va !== exp_a(k)) $display("FAIL h_sweep k=%0d got=%h exp=%h", k, va, exp_a(k));
      else n_pass++;
      if (pt_a && !hs_a && y_a == 10'd0) hs_low++;
      if (pt_a && x_a == 10'd799) wraps++;
    end
    n_chk++;
    if (hs_low !== 96) $display("FAIL hsync_width got=%0d exp=96", hs_low);
    else n_pass++;
    n_chk++;
    if (wraps !== 3) $display("FAIL line_wraps got=%0d exp=3", wraps);
    else n_pass++;
  endtask

  task automatic test_small_frames();
    int last  = -1;
    int nft   = 0;
    int vlow  = 0;
    int y5x0  = 0;
    reset_release();
    repeat (3 * 448) begin
      @(negedge clk);
      n_chk++;
      if (vb !== exp_b(k)) $display("FAIL small k=%0d got=%h exp=%h", k, vb, exp_b(k));
      else n_pass++;
      if (pt_b && !vs_b) vlow++;
      if (pt_b && y_b == 10'd5 && x_b == 10'd0) y5x0++;
      if (ft_b) begin
        nft++;
        if (last >= 0) begin
          n_chk++;
          if (k - last !== 448) $display("FAIL frame_period got=%0d exp=448", k - last);
          else n_pass++;
        end
        last = k;
      end
    end
    repeat ($urandom_range(0, 447)) begin
      @(negedge clk);
      n_chk++;
      if (vb !== exp_b(k)) $display("FAIL small_tail k=%0d got=%h exp=%h", k, vb, exp_b(k));
      else n_pass++;
    end
    n_chk++;
    if (nft !== 3) $display("FAIL frame_count got=%0d exp=3", nft);
    else n_pass++;
    n_chk++;
    if (vlow !== 48) $display("FAIL vsync_width got=%0d exp=48", vlow);
    else n_pass++;
    n_chk++;
    if (y5x0 !== 3) $display("FAIL y5x0_once got=%0d exp=3", y5x0);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    repeat (3) begin
      reset_release();
      repeat ($urandom_range(50, 4000)) begin
        @(negedge clk);
        n_chk++;
        if (va !== exp_a(k)) $display("FAIL pre_reset_a k=%0d got=%h exp=%h", k, va, exp_a(k));
        else n_pass++;
        n_chk++;
        if (vb !== exp_b(k)) $display("FAIL pre_reset_b k=%0d got=%h exp=%h", k, vb, exp_b(k));
        else n_pass++;
      end
      #2 rstn = 1'b0;
      #1;
      n_chk++;
      if (va !== RST_V) $display("FAIL async_reset_a got=%h exp=%h", va, RST_V);
      else n_pass++;
      n_chk++;
      if (vb !== RST_V) $display("FAIL async_reset_b got=%h exp=%h", vb, RST_V);
      else n_pass++;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rstn = 1'b1;
      repeat (1700) begin
        @(negedge clk);
        n_chk++;
        if (va !== exp_a(k)) $display("FAIL post_reset_a k=%0d got=%h exp=%h", k, va, exp_a(k));
        else n_pass++;
        n_chk++;
        if (vb !== exp_b(k)) $display("FAIL post_reset_b k=%0d got=%h exp=%h", k, vb, exp_b(k));
        else n_pass++;
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    test_reset();
    test_first_ticks();
    test_h_sweep();
    test_small_frames();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
